// File: rtl/rf_wb_arbiter.sv
// Write-back arbiter and load scoreboard: merges ALU and load results onto the
// single register-file write port and stalls decode on hazards against pending loads.
module rf_wb_arbiter #(
  parameter int Width = 32
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             alu_valid_i,
  input  logic [4:0]       alu_rd_i,
  input  logic [Width-1:0] alu_data_i,
  output logic             alu_ready_o,
  input  logic             lsu_issue_i,
  input  logic [4:0]       lsu_issue_rd_i,
  input  logic             lsu_valid_i,
  input  logic [4:0]       lsu_rd_i,
  input  logic [Width-1:0] lsu_data_i,
  input  logic [2:0]       lsu_type_i,
  output logic             lsu_ready_o,
  input  logic [4:0]       rs1_i,
  input  logic [4:0]       rs2_i,
  input  logic [4:0]       rd_i,
  output logic             stall_o,
  output logic             rf_wen_o,
  output logic [4:0]       rf_rw_o,
  output logic [Width-1:0] rf_busw_o,
  output logic             rf_lb_o,
  output logic             rf_lh_o,
  output logic             rf_lbu_o,
  output logic             rf_lhu_o,
  output logic [31:0]      busy_o,
  output logic             err_o
);

  logic             r_alu_wait;
  logic             r_wen;
  logic [4:0]       r_rw;
  logic [Width-1:0] r_busw;
  logic [3:0]       r_ext;
  logic             r_is_lsu;
  logic [31:0]      r_busy;
  logic             r_err;

  logic             w_lsu_gnt;
  logic             w_alu_gnt;
  logic [3:0]       w_lsu_ext;
  logic [31:0]      w_clr_mask;
  logic [31:0]      w_busy_eff;
  logic [31:0]      w_busy_nxt;
  logic             w_err_set;

  // LSU wins by default; a previously denied ALU request takes the next turn.
  always_comb begin
    w_lsu_gnt = rst_ni & lsu_valid_i & (~alu_valid_i | ~r_alu_wait);
    w_alu_gnt = rst_ni & alu_valid_i & ~w_lsu_gnt;
  end

  always_comb begin
    w_lsu_ext = 4'b0000;
    case (lsu_type_i)
      3'd1:    w_lsu_ext = 4'b1000;
      3'd2:    w_lsu_ext = 4'b0100;
      3'd3:    w_lsu_ext = 4'b0010;
      3'd4:    w_lsu_ext = 4'b0001;
      default: w_lsu_ext = 4'b0000;
    endcase
  end

  // The load write happening this cycle retires its busy bit at the coming edge;
  // hazard and error checks see the scoreboard with that retirement applied.
  always_comb begin
    w_clr_mask = '0;
    if (r_wen && r_is_lsu) begin
      w_clr_mask[r_rw] = 1'b1;
    end
    w_busy_eff = r_busy & ~w_clr_mask;
    w_busy_nxt = w_busy_eff;
    if (lsu_issue_i && (lsu_issue_rd_i != 5'd0)) begin
      w_busy_nxt[lsu_issue_rd_i] = 1'b1;
    end
    w_busy_nxt[0] = 1'b0;
  end

  always_comb begin
    w_err_set = (lsu_issue_i & w_busy_eff[lsu_issue_rd_i])
              | (w_lsu_gnt & ~w_busy_eff[lsu_rd_i])
              | (w_alu_gnt & w_busy_eff[alu_rd_i]);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_alu_wait <= 1'b0;
    end else if (alu_valid_i) begin
      r_alu_wait <= ~w_alu_gnt;
    end
  end

  // Output register: loads on any handshake; x0 writes never raise the enable.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_wen    <= 1'b0;
      r_rw     <= 5'd0;
      r_busw   <= '0;
      r_ext    <= 4'b0000;
      r_is_lsu <= 1'b0;
    end else if (w_lsu_gnt) begin
      r_wen    <= (lsu_rd_i != 5'd0);
      r_rw     <= lsu_rd_i;
      r_busw   <= lsu_data_i;
      r_ext    <= w_lsu_ext;
      r_is_lsu <= 1'b1;
    end else if (w_alu_gnt) begin
      r_wen    <= (alu_rd_i != 5'd0);
      r_rw     <= alu_rd_i;
      r_busw   <= alu_data_i;
      r_ext    <= 4'b0000;
      r_is_lsu <= 1'b0;
    end else begin
      r_wen    <= 1'b0;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      r_busy <= '0;
      r_err  <= 1'b0;
    end else begin
      r_busy <= w_busy_nxt;
      r_err  <= r_err | w_err_set;
    end
  end

  assign alu_ready_o = w_alu_gnt;
  assign lsu_ready_o = w_lsu_gnt;
  assign stall_o     = r_busy[rs1_i] | r_busy[rs2_i] | r_busy[rd_i];
  assign rf_wen_o    = r_wen;
  assign rf_rw_o     = r_rw;
  assign rf_busw_o   = r_busw;
  assign rf_lb_o     = r_ext[3];
  assign rf_lh_o     = r_ext[2];
  assign rf_lbu_o    = r_ext[1];
  assign rf_lhu_o    = r_ext[0];
  assign busy_o      = r_busy;
  assign err_o       = r_err;

endmodule

// File: tb/tb_rf_wb_arbiter.sv
// Bench for rf_wb_arbiter: directed and random traffic against a queue-based
// reference model, with write-backs checked by a separate scoreboard monitor.
module tb_rf_wb_arbiter;
  localparam int Width = 32;

  logic             clk_i = 1'b0;
  logic             rst_ni = 1'b0;
  logic             alu_valid_i, lsu_issue_i, lsu_valid_i;
  logic [4:0]       alu_rd_i, lsu_issue_rd_i, lsu_rd_i, rs1_i, rs2_i, rd_i;
  logic [Width-1:0] alu_data_i, lsu_data_i;
  logic [2:0]       lsu_type_i;
  logic             alu_ready_o, lsu_ready_o, stall_o, rf_wen_o;
  logic [4:0]       rf_rw_o;
  logic [Width-1:0] rf_busw_o;
  logic             rf_lb_o, rf_lh_o, rf_lbu_o, rf_lhu_o, err_o;
  logic [31:0]      busy_o;

  always #5 clk_i = ~clk_i;

  rf_wb_arbiter #(.Width(Width)) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .alu_valid_i(alu_valid_i), .alu_rd_i(alu_rd_i), .alu_data_i(alu_data_i),
    .alu_ready_o(alu_ready_o),
    .lsu_issue_i(lsu_issue_i), .lsu_issue_rd_i(lsu_issue_rd_i),
    .lsu_valid_i(lsu_valid_i), .lsu_rd_i(lsu_rd_i), .lsu_data_i(lsu_data_i),
    .lsu_type_i(lsu_type_i), .lsu_ready_o(lsu_ready_o),
    .rs1_i(rs1_i), .rs2_i(rs2_i), .rd_i(rd_i), .stall_o(stall_o),
    .rf_wen_o(rf_wen_o), .rf_rw_o(rf_rw_o), .rf_busw_o(rf_busw_o),
    .rf_lb_o(rf_lb_o), .rf_lh_o(rf_lh_o), .rf_lbu_o(rf_lbu_o), .rf_lhu_o(rf_lhu_o),
    .busy_o(busy_o), .err_o(err_o)
  );

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] data;
    logic [3:0]  ext;
    int          cyc;
  } wb_t;

  wb_t         sbq[$];
  wb_t         monEntry;
  int          checks = 0;
  int          errors = 0;
  int          cycleNo = 0;
  logic [31:0] mBusy = '0;
  bit          mAluWait = 1'b0;
  bit          mErr = 1'b0;
  int          pendLsuRd = 0;
  int          outstanding[$];

  always @(posedge clk_i) cycleNo <= cycleNo + 1;

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %h expected %h at t=%0t", name, act, exp, $time);
    end
  endtask

  // Extension flags as {lb, lh, lbu, lhu} from the load type table.
  function automatic logic [3:0] extOf(input logic [2:0] t);
    case (t)
      3'd1:    return 4'b1000;
      3'd2:    return 4'b0100;
      3'd3:    return 4'b0010;
      3'd4:    return 4'b0001;
      default: return 4'b0000;
    endcase
  endfunction

  // Busy set as seen at the coming edge, after the load being written now retires.
  function automatic logic [31:0] effNow();
    logic [31:0] b;
    b = mBusy;
    b[pendLsuRd] = 1'b0;
    return b;
  endfunction

  task automatic dropOutstanding(input int rd);
    for (int i = 0; i < outstanding.size(); i++) begin
      if (outstanding[i] == rd) begin
        outstanding.delete(i);
        return;
      end
    end
  endtask

  task automatic setIdle();
    alu_valid_i = 0; alu_rd_i = 0; alu_data_i = 0;
    lsu_issue_i = 0; lsu_issue_rd_i = 0;
    lsu_valid_i = 0; lsu_rd_i = 0; lsu_data_i = 0; lsu_type_i = 0;
    rs1_i = 0; rs2_i = 0; rd_i = 0;
  endtask

  // Runs one clock with the currently driven inputs, checks combinational
  // outputs mid-cycle, queues the expected write-back and advances the model.
  task automatic applyStimulus();
    logic [31:0] eff;
    bit gLsu, gAlu, expStall;
    wb_t e;
    eff = effNow();
    gLsu = lsu_valid_i && (!alu_valid_i || !mAluWait);
    gAlu = alu_valid_i && !gLsu;
    expStall = mBusy[rs1_i] || mBusy[rs2_i] || mBusy[rd_i];
    @(negedge clk_i);
    checkOutput("lsu_ready", 32'(lsu_ready_o), 32'(gLsu));
    checkOutput("alu_ready", 32'(alu_ready_o), 32'(gAlu));
    checkOutput("stall", 32'(stall_o), 32'(expStall));
    checkOutput("busy", busy_o, mBusy);
    checkOutput("err", 32'(err_o), 32'(mErr));
    if (gLsu) begin
      if (!eff[lsu_rd_i]) mErr = 1'b1;
      if (lsu_rd_i != 0) begin
        e.rd = lsu_rd_i; e.data = lsu_data_i; e.ext = extOf(lsu_type_i); e.cyc = cycleNo;
        sbq.push_back(e);
      end
      dropOutstanding(int'(lsu_rd_i));
    end
    if (gAlu) begin
      if (eff[alu_rd_i]) mErr = 1'b1;
      if (alu_rd_i != 0) begin
        e.rd = alu_rd_i; e.data = alu_data_i; e.ext = 4'b0000; e.cyc = cycleNo;
        sbq.push_back(e);
      end
    end
    if (lsu_issue_i && eff[lsu_issue_rd_i]) mErr = 1'b1;
    mBusy = eff;
    if (lsu_issue_i && lsu_issue_rd_i != 0) begin
      mBusy[lsu_issue_rd_i] = 1'b1;
      outstanding.push_back(int'(lsu_issue_rd_i));
    end
    if (alu_valid_i) mAluWait = !gAlu;
    pendLsuRd = gLsu ? int'(lsu_rd_i) : 0;
    @(posedge clk_i);
    #1;
  endtask

  // Asserts reset between edges with requests pending and checks that every
  // output drops immediately; the model forgets any pending write.
  task automatic doReset();
    alu_valid_i = 1; lsu_valid_i = 1; lsu_rd_i = 5'd7; rs1_i = 5'd7;
    #2 rst_ni = 1'b0;
    #1;
    checkOutput("rst_alu_ready", 32'(alu_ready_o), 0);
    checkOutput("rst_lsu_ready", 32'(lsu_ready_o), 0);
    checkOutput("rst_wen", 32'(rf_wen_o), 0);
    checkOutput("rst_rw", 32'(rf_rw_o), 0);
    checkOutput("rst_busw", rf_busw_o, 0);
    checkOutput("rst_flags", 32'({rf_lb_o, rf_lh_o, rf_lbu_o, rf_lhu_o}), 0);
    checkOutput("rst_busy", busy_o, 0);
    checkOutput("rst_err", 32'(err_o), 0);
    checkOutput("rst_stall", 32'(stall_o), 0);
    sbq.delete();
    outstanding.delete();
    mBusy = '0; mAluWait = 1'b0; mErr = 1'b0; pendLsuRd = 0;
    setIdle();
    @(negedge clk_i);
    rst_ni = 1'b1;
    @(posedge clk_i);
    #1;
  endtask

  // Scoreboard monitor: every register-file write must match the oldest
  // expected entry and appear exactly one cycle after its handshake.
  always @(negedge clk_i) begin
    if (rst_ni) begin
      if (rf_wen_o) begin
        if (sbq.size() == 0 || sbq[0].cyc >= cycleNo) begin
          checks++; errors++;
          $display("[TB] FAIL unexpected_write: got rw=%0d data=%h expected no write", rf_rw_o, rf_busw_o);
        end else begin
          monEntry = sbq.pop_front();
          checkOutput("wb_rd", 32'(rf_rw_o), 32'(monEntry.rd));
          checkOutput("wb_data", rf_busw_o, monEntry.data);
          checkOutput("wb_flags", 32'({rf_lb_o, rf_lh_o, rf_lbu_o, rf_lhu_o}), 32'(monEntry.ext));
          checkOutput("wb_latency", 32'(cycleNo - monEntry.cyc), 32'd1);
        end
      end else if (sbq.size() > 0 && sbq[0].cyc < cycleNo) begin
        monEntry = sbq.pop_front();
        checks++; errors++;
        $display("[TB] FAIL missing_write: got no write expected rw=%0d data=%h", monEntry.rd, monEntry.data);
      end
    end
  end

  initial begin
    logic [31:0] eff;
    logic [4:0]  r;
    setIdle();
    @(posedge clk_i);
    #1;
    doReset();

    // ALU write
    alu_valid_i = 1; alu_rd_i = 5; alu_data_i = 32'h1234_5678;
    applyStimulus();
    setIdle(); applyStimulus();

    // Load scoreboard: issue x7, stall, return LB, stall releases
    lsu_issue_i = 1; lsu_issue_rd_i = 7;
    applyStimulus();
    setIdle(); rs1_i = 7;
    applyStimulus();
    checkOutput("busy_x7", busy_o, 32'h0000_0080);
    lsu_valid_i = 1; lsu_rd_i = 7; lsu_type_i = 1; lsu_data_i = 32'h0000_00FF;
    applyStimulus();
    setIdle(); rs1_i = 7;
    applyStimulus();
    applyStimulus();
    applyStimulus();

    // Contention: x4 reissued on the edge its first write-back retires
    lsu_issue_i = 1; lsu_issue_rd_i = 4;
    applyStimulus();
    setIdle();
    for (int i = 0; i < 4; i++) begin
      alu_valid_i = 1; alu_rd_i = 3; alu_data_i = 32'hA000_0000 + 32'(i);
      lsu_valid_i = 1; lsu_rd_i = 4; lsu_data_i = 32'hB000_0000 + 32'(i); lsu_type_i = 0;
      lsu_issue_i = (i == 1); lsu_issue_rd_i = 4;
      applyStimulus();
    end
    setIdle(); applyStimulus(); applyStimulus();

    // Same-edge set/clear on x6
    lsu_issue_i = 1; lsu_issue_rd_i = 6; applyStimulus();
    setIdle(); lsu_valid_i = 1; lsu_rd_i = 6; lsu_type_i = 4; lsu_data_i = 32'h0000_8001;
    applyStimulus();
    setIdle(); lsu_issue_i = 1; lsu_issue_rd_i = 6; applyStimulus();
    setIdle(); applyStimulus();
    checkOutput("busy6_set_wins", 32'(busy_o[6]), 1);
    lsu_valid_i = 1; lsu_rd_i = 6; lsu_type_i = 2; lsu_data_i = 32'hFFFF_8000;
    applyStimulus();
    setIdle(); applyStimulus(); applyStimulus();

    // ALU write to x0
    alu_valid_i = 1; alu_rd_i = 0; alu_data_i = 32'hDEAD_BEEF;
    applyStimulus();
    setIdle(); applyStimulus();

    // Random legal traffic
    for (int n = 0; n < 400; n++) begin
      eff = effNow();
      setIdle();
      rs1_i = 5'($urandom_range(31)); rs2_i = 5'($urandom_range(31)); rd_i = 5'($urandom_range(31));
      if ($urandom_range(1) == 1) begin
        do r = 5'($urandom_range(31)); while (eff[r]);
        alu_valid_i = 1; alu_rd_i = r; alu_data_i = $urandom;
      end
      if (outstanding.size() > 0 && $urandom_range(1) == 1) begin
        lsu_valid_i = 1;
        lsu_rd_i = 5'(outstanding[$urandom_range(outstanding.size() - 1)]);
        lsu_data_i = $urandom; lsu_type_i = 3'($urandom_range(7));
      end
      if (outstanding.size() < 8 && $urandom_range(9) < 3) begin
        do r = 5'($urandom_range(31)); while (eff[r]);
        lsu_issue_i = 1; lsu_issue_rd_i = r;
      end
      applyStimulus();
    end
    setIdle();
    for (int n = 0; n < 3; n++) applyStimulus();

    // Reset while a write is pending on the output register
    alu_valid_i = 1; alu_rd_i = 12; alu_data_i = 32'h0BAD_F00D;
    lsu_issue_i = 1; lsu_issue_rd_i = 13;
    applyStimulus();
    doReset();
    applyStimulus();

    // Double issue of x9 -> sticky error
    lsu_issue_i = 1; lsu_issue_rd_i = 9; applyStimulus();
    applyStimulus();
    setIdle();
    for (int n = 0; n < 4; n++) applyStimulus();
    checkOutput("err_sticky", 32'(err_o), 1);
    doReset();

    // ALU write to a busy register -> error
    lsu_issue_i = 1; lsu_issue_rd_i = 10; applyStimulus();
    setIdle(); alu_valid_i = 1; alu_rd_i = 10; alu_data_i = 32'h55; applyStimulus();
    setIdle(); applyStimulus(); applyStimulus();
    doReset();

    // Load return to a non-busy register -> error
    lsu_valid_i = 1; lsu_rd_i = 11; lsu_data_i = 32'h77; lsu_type_i = 3; applyStimulus();
    setIdle(); applyStimulus(); applyStimulus();

    checkOutput("sb_empty", 32'(sbq.size()), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
